// File: rtl/trace_capture_if.sv
// Byte-stream handshake carrying serialized trace frames.
// master drives tx_data/tx_valid, slave drives tx_ready.
interface trace_capture_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/trace_capture.sv
// Commit-trace capture: buffers retired-instruction records, emits 17-byte frames.
// Ports: clk/rst_n, capture controls, core debug bundle, clear, tx stream, status.
module trace_capture #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     effects_only,
  input  logic [31:0]              pc,
  input  logic [31:0]              instr,
  input  logic [31:0]              alu_result,
  input  logic [31:0]              write_data,
  input  logic                     reg_write,
  input  logic                     mem_write,
  input  logic                     pc_src,
  input  logic [3:0]               nzcv,
  input  logic                     clear,
  trace_capture_if.master          tx,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]        drop_count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = 136;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t          r_state;
  logic [FW-1:0]   r_mem [DEPTH];
  logic [AW:0]     r_wr;
  logic [AW:0]     r_rd;
  logic            r_lost;
  logic [DROP_W-1:0] r_drop;
  logic            r_ovf;
  logic [FW-9:0]   r_shift;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic [4:0]      r_idx;

  logic            w_cap;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;
  logic            w_last;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic [7:0]      w_hdr;
  logic [FW-1:0]   w_rec;
  logic [FW-1:0]   w_head;

  assign w_cap = enable &
    (~effects_only | reg_write | mem_write | pc_src);

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);

  assign w_accept = r_tx_valid & tx.tx_ready;
  assign w_last   = (r_idx == 5'd16);

  // Head leaves the FIFO either from idle or right as the last
  // byte of the current frame is taken (back-to-back frames).
  assign w_pop = ~w_empty &
    ((r_state == IDLE) | (w_accept & w_last));

  // A full FIFO still accepts when the same edge frees a slot.
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;

  assign w_hdr = {reg_write, mem_write, pc_src, r_lost, nzcv};
  // Byte 0 in the low bits; each word little-endian after it.
  assign w_rec = {write_data, alu_result, instr, pc, w_hdr};

  assign w_head = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= w_rec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_lost <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push)      r_lost <= 1'b0;
      else if (w_drop) r_lost <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
      r_ovf  <= 1'b0;
    end else if (clear) begin
      r_drop <= {{(DROP_W-1){1'b0}}, w_drop};
      r_ovf  <= w_drop;
    end else if (w_drop) begin
      if (~&r_drop) r_drop <= r_drop + 1'b1;
      r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_idx      <= 5'd0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift    <= w_head[FW-1:8];
            r_tx_data  <= w_head[7:0];
            r_idx      <= 5'd0;
            r_tx_valid <= 1'b1;
            r_state    <= SEND;
          end
        end
        SEND: begin
          if (w_accept) begin
            if (!w_last) begin
              r_tx_data <= r_shift[7:0];
              r_shift   <= r_shift >> 8;
              r_idx     <= r_idx + 5'd1;
            end else if (w_pop) begin
              r_shift   <= w_head[FW-1:8];
              r_tx_data <= w_head[7:0];
              r_idx     <= 5'd0;
            end else begin
              r_tx_valid <= 1'b0;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;

  assign fifo_count = r_wr - r_rd;
  assign drop_count = r_drop;
  assign overflow   = r_ovf;
  assign busy       = ~w_empty | r_tx_valid;

endmodule

// File: tb/tb_trace_capture.sv
// Self-checking bench for trace_capture: directed cases plus random traffic
// against a queue-based reference of the capture/frame rules.
module tb_trace_capture;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable, effects_only, clear;
  logic [31:0] pc, instr, alu_result, write_data;
  logic        reg_write, mem_write, pc_src;
  logic [3:0]  nzcv;
  logic [3:0]  fifo_count;
  logic [15:0] drop_count;
  logic        overflow, busy;

  trace_capture_if u_if();

  trace_capture #(.DEPTH(DEPTH), .DROP_W(DROP_W)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .enable(enable), .effects_only(effects_only),
    .pc(pc), .instr(instr),
    .alu_result(alu_result), .write_data(write_data),
    .reg_write(reg_write), .mem_write(mem_write),
    .pc_src(pc_src), .nzcv(nzcv), .clear(clear),
    .tx(u_if),
    .fifo_count(fifo_count), .drop_count(drop_count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: pending records, frame on the wire, bytes left in it.
  bit [135:0] m_q[$];
  bit [135:0] m_cur;
  int         m_rem;
  bit         m_lost;
  int         m_drops;
  bit         m_ovf;
  logic [7:0] got_q[$];

  task automatic model_reset();
    m_q.delete();
    m_cur = '0; m_rem = 0; m_lost = 0;
    m_drops = 0; m_ovf = 0;
  endtask

  task automatic model_edge();
    bit acc, cap, full, pop, dropped;
    acc  = (m_rem > 0) && u_if.tx_ready;
    cap  = enable && (!effects_only || reg_write || mem_write || pc_src);
    full = (m_q.size() == DEPTH);
    pop  = (m_q.size() > 0) && (m_rem == 0 || (acc && m_rem == 1));
    dropped = 0;
    if (acc) begin
      m_rem--;
      m_cur = m_cur >> 8;
    end
    if (pop) begin
      m_cur = m_q.pop_front();
      m_rem = 17;
    end
    if (cap) begin
      if (!full || pop) begin
        m_q.push_back({write_data, alu_result, instr, pc,
                       reg_write, mem_write, pc_src, m_lost, nzcv});
        m_lost = 0;
      end else begin
        dropped = 1;
        m_lost = 1;
      end
    end
    if (clear) begin
      m_drops = dropped ? 1 : 0;
      m_ovf = dropped;
    end else if (dropped) begin
      if (m_drops < 65535) m_drops++;
      m_ovf = 1;
    end
  endtask

  task automatic check_outputs();
    chk("tx_valid", u_if.tx_valid, m_rem > 0);
    if (m_rem > 0) chk("tx_data", u_if.tx_data, m_cur[7:0]);
    chk("fifo_count", fifo_count, m_q.size());
    chk("drop_count", drop_count, m_drops);
    chk("overflow", overflow, m_ovf);
    chk("busy", busy, (m_q.size() > 0) || (m_rem > 0));
  endtask

  task automatic cycle();
    if (u_if.tx_valid && u_if.tx_ready) got_q.push_back(u_if.tx_data);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    enable = 0; effects_only = 0; clear = 0;
    reg_write = 0; mem_write = 0; pc_src = 0;
    nzcv = 0; pc = 0; instr = 0; alu_result = 0; write_data = 0;
  endtask

  task automatic rand_data();
    pc = $urandom; instr = $urandom;
    alu_result = $urandom; write_data = $urandom;
    nzcv = 4'($urandom);
    reg_write = 1'($urandom);
    mem_write = 1'($urandom);
    pc_src = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    u_if.tx_ready = 0;
    @(negedge clk);
    model_reset();
    chk("rst_valid", u_if.tx_valid, 0);
    chk("rst_data", u_if.tx_data, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_drops", drop_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1;
    got_q.delete();
  endtask

  task automatic drain(input int max);
    enable = 0; clear = 0;
    u_if.tx_ready = 1;
    for (int i = 0; i < max; i++) begin
      if (!busy) break;
      cycle();
    end
    chk("drain_done", busy, 0);
  endtask

  logic [7:0]   exp1 [17];
  logic [135:0] f;
  logic [7:0]   h;
  int           nfr;

  initial begin
    idle_inputs();
    u_if.tx_ready = 0;
    exp1 = '{8'h80, 8'h10, 8'h00, 8'h00, 8'h00,
             8'h01, 8'h10, 8'h81, 8'hE2,
             8'h05, 8'h00, 8'h00, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00};

    // Single record, latency and exact byte image.
    do_reset();
    pc = 32'h10; instr = 32'hE2811001;
    alu_result = 32'h5; write_data = 0;
    reg_write = 1; enable = 1; u_if.tx_ready = 1;
    cycle();
    chk("lat_count1", fifo_count, 1);
    chk("lat_valid0", u_if.tx_valid, 0);
    enable = 0;
    cycle();
    chk("lat_valid1", u_if.tx_valid, 1);
    chk("lat_hdr", u_if.tx_data, 8'h80);
    chk("lat_count0", fifo_count, 0);
    drain(40);
    chk("single_len", got_q.size(), 17);
    for (int i = 0; i < 17 && i < got_q.size(); i++)
      chk("single_byte", got_q[i], exp1[i]);

    // Backpressure with ready pattern 1,0,0,1.
    do_reset();
    rand_data();
    reg_write = 1;
    f = {write_data, alu_result, instr, pc,
         reg_write, mem_write, pc_src, 1'b0, nzcv};
    enable = 1; u_if.tx_ready = 1;
    cycle();
    idle_inputs();
    for (int c = 0; c < 100; c++) begin
      u_if.tx_ready = (c % 4 == 0) || (c % 4 == 3);
      cycle();
      if (!busy) break;
    end
    chk("bp_len", got_q.size(), 17);
    for (int i = 0; i < 17 && i < got_q.size(); i++)
      chk("bp_byte", got_q[i], f[8*i +: 8]);

    // Overflow: 12 captures while stalled. The first record moves into
    // the frame register, so 1 + DEPTH are held and the rest drop.
    do_reset();
    effects_only = 0; enable = 1;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      cycle();
    end
    chk("ovf_count", fifo_count, DEPTH);
    chk("ovf_drops", drop_count, 12 - 1 - DEPTH);
    chk("ovf_flag", overflow, 1);
    enable = 0; u_if.tx_ready = 1;
    for (int c = 0; c < 20; c++) cycle();
    rand_data(); enable = 1;
    cycle();
    drain(400);
    nfr = got_q.size() / 17;
    chk("ovf_frames", nfr, 10);
    for (int k = 0; k < nfr; k++) begin
      h = got_q[17*k];
      chk("ovf_lostbit", h[4], k == nfr - 1);
    end

    // effects_only filter.
    do_reset();
    effects_only = 1; enable = 1;
    for (int c = 0; c < 5; c++) begin
      rand_data();
      reg_write = 0; mem_write = 0; pc_src = 0;
      cycle();
    end
    rand_data();
    reg_write = 0; mem_write = 1; pc_src = 0; nzcv = 4'hA;
    cycle();
    drain(60);
    chk("eo_len", got_q.size(), 17);
    if (got_q.size() > 0) chk("eo_hdr", got_q[0], 8'h4A);

    // Full FIFO with same-edge pop, then clear behaviour.
    do_reset();
    enable = 1;
    for (int c = 0; c < 9; c++) begin
      rand_data();
      cycle();
    end
    chk("full_count", fifo_count, DEPTH);
    chk("full_drops", drop_count, 0);
    enable = 0; u_if.tx_ready = 1;
    for (int c = 0; c < 16; c++) cycle();
    rand_data(); enable = 1;
    cycle();
    chk("samepop_count", fifo_count, DEPTH);
    chk("samepop_drops", drop_count, 0);
    u_if.tx_ready = 0;
    rand_data();
    cycle();
    chk("drop1_drops", drop_count, 1);
    chk("drop1_ovf", overflow, 1);
    enable = 0; clear = 1;
    cycle();
    chk("clr_drops", drop_count, 0);
    chk("clr_ovf", overflow, 0);
    enable = 1;
    cycle();
    chk("clrdrop_drops", drop_count, 1);
    chk("clrdrop_ovf", overflow, 1);
    clear = 0;
    drain(400);

    // Asynchronous reset in the middle of a frame.
    do_reset();
    enable = 1;
    for (int c = 0; c < 4; c++) begin
      rand_data();
      cycle();
    end
    enable = 0; u_if.tx_ready = 1;
    for (int c = 0; c < 6; c++) cycle();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", u_if.tx_valid, 0);
    chk("arst_count", fifo_count, 0);
    chk("arst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    got_q.delete();
    for (int c = 0; c < 20; c++) cycle();
    chk("arst_nobytes", got_q.size(), 0);

    // Random traffic against the reference.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_data();
      enable = ($urandom % 4) != 0;
      effects_only = ($urandom % 4) == 0;
      reg_write = ($urandom % 3) == 0;
      mem_write = ($urandom % 4) == 0;
      pc_src = ($urandom % 5) == 0;
      clear = ($urandom % 60) == 0;
      if ((c / 200) % 3 == 2) u_if.tx_ready = ($urandom % 8) == 0;
      else u_if.tx_ready = ($urandom % 3) != 0;
      cycle();
    end
    drain(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
